line_rasterizer: RTL

- Pixel producer that drives the write side of the VGA framebuffer: accepts one line-draw command (two endpoints, colour, depth) and emits one pixel write per clock along the Bresenham path.
- Sits between the shader/command logic and the framebuffer write port (x, y, z, pixel_color, pixel_write).
- Clips to the 640x480 active area by suppressing pixel_write; path stepping is unaffected by clipping.

---
 rtl/gfx_pkg.sv | 26 ++
 rtl/bresenham_step.sv | 40 ++++
 rtl/line_rasterizer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the line rasterizer and its stepper.
package gfx_pkg;

  localparam int COORD_W = 11;
  localparam int HACTIVE = 640;
  localparam int VACTIVE = 480;
  // Signed working width: two guard bits so that 2*err never overflows.
  localparam int SW      = COORD_W + 2;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [1:0]           color_t;
  typedef logic signed [SW-1:0] scoord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // True when the pixel lies inside the visible 640x480 area.
  function automatic logic in_active(input coord_t px, input coord_t py);
    return (px < coord_t'(HACTIVE)) && (py < coord_t'(VACTIVE));
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: next error term and next point, plus an
// end-of-line flag. Both axis decisions use the same (old) error value.
module bresenham_step
  import gfx_pkg::*;
(
  input  scoord_t err,
  input  scoord_t dx,
  input  scoord_t dy,
  input  logic    sx_neg,
  input  logic    sy_neg,
  input  coord_t  cur_x,
  input  coord_t  cur_y,
  input  coord_t  end_x,
  input  coord_t  end_y,
  output scoord_t next_err,
  output coord_t  next_x,
  output coord_t  next_y,
  output logic    at_end
);

  scoord_t e2;

  // Evaluate both step conditions against the old error and accumulate.
  always_comb begin
    e2       = err <<< 1;
    next_err = err;
    next_x   = cur_x;
    next_y   = cur_y;
    if (e2 >= dy) begin
      next_err = next_err + dy;
      next_x   = sx_neg ? (cur_x - coord_t'(1)) : (cur_x + coord_t'(1));
    end
    if (e2 <= dx) begin
      next_err = next_err + dx;
      next_y   = sy_neg ? (cur_y - coord_t'(1)) : (cur_y + coord_t'(1));
    end
    at_end = (cur_x == end_x) && (cur_y == end_y);
  end

endmodule

// File: rtl/line_rasterizer.sv
// Line rasterizer: takes one line command and emits one framebuffer write per
// clock along the Bresenham path, clipping writes to the visible area.
//
// Command handshake: start is sampled only while idle (busy=0, done=0 shown
// by dbg_state==IDLE); the accepted command is latched and busy rises in the
// next cycle. start at any other time is ignored. done pulses for one cycle
// after the last pixel, and a new start is accepted from the cycle after it.
module line_rasterizer
  import gfx_pkg::*;
(
  input  logic   clk50,
  input  logic   reset_n,
  input  logic   start,
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t z_in,
  input  color_t color_in,
  output logic   busy,
  output logic   done,
  output coord_t x,
  output coord_t y,
  output coord_t z,
  output color_t pixel_color,
  output logic   pixel_write,
  output state_t dbg_state
);

  state_t  state_q, state_d;
  coord_t  cmd_x0_q, cmd_x0_d, cmd_y0_q, cmd_y0_d;
  coord_t  cmd_x1_q, cmd_x1_d, cmd_y1_q, cmd_y1_d;
  coord_t  cmd_z_q, cmd_z_d;
  color_t  cmd_color_q, cmd_color_d;
  scoord_t err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  coord_t  x_q, x_d, y_q, y_d, z_q, z_d;
  color_t  color_q, color_d;
  logic    busy_q, busy_d, done_q, done_d, pw_q, pw_d;

  scoord_t step_err;
  coord_t  step_x, step_y;
  logic    step_at_end;
  coord_t  abs_dx, abs_dy;

  bresenham_step u_step (
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .sx_neg   (sx_neg_q),
    .sy_neg   (sy_neg_q),
    .cur_x    (x_q),
    .cur_y    (y_q),
    .end_x    (cmd_x1_q),
    .end_y    (cmd_y1_q),
    .next_err (step_err),
    .next_x   (step_x),
    .next_y   (step_y),
    .at_end   (step_at_end)
  );

  // Next-state logic for the command FSM, line setup and pixel outputs.
  always_comb begin
    state_d     = state_q;
    cmd_x0_d    = cmd_x0_q;
    cmd_y0_d    = cmd_y0_q;
    cmd_x1_d    = cmd_x1_q;
    cmd_y1_d    = cmd_y1_q;
    cmd_z_d     = cmd_z_q;
    cmd_color_d = cmd_color_q;
    err_d       = err_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    color_d     = color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pw_d        = 1'b0;

    abs_dx = (cmd_x1_q >= cmd_x0_q) ? (cmd_x1_q - cmd_x0_q) : (cmd_x0_q - cmd_x1_q);
    abs_dy = (cmd_y1_q >= cmd_y0_q) ? (cmd_y1_q - cmd_y0_q) : (cmd_y0_q - cmd_y1_q);

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          cmd_x0_d    = x0;
          cmd_y0_d    = y0;
          cmd_x1_d    = x1;
          cmd_y1_d    = y1;
          cmd_z_d     = z_in;
          cmd_color_d = color_in;
          busy_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        dx_d     = $signed({2'b00, abs_dx});
        dy_d     = -$signed({2'b00, abs_dy});
        err_d    = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
        sx_neg_d = !(cmd_x0_q < cmd_x1_q);
        sy_neg_d = !(cmd_y0_q < cmd_y1_q);
        x_d      = cmd_x0_q;
        y_d      = cmd_y0_q;
        z_d      = cmd_z_q;
        color_d  = cmd_color_q;
        pw_d     = in_active(cmd_x0_q, cmd_y0_q);
        state_d  = DRAW;
      end
      DRAW: begin
        if (step_at_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          err_d = step_err;
          x_d   = step_x;
          y_d   = step_y;
          pw_d  = in_active(step_x, step_y);
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_x0_q    <= '0;
      cmd_y0_q    <= '0;
      cmd_x1_q    <= '0;
      cmd_y1_q    <= '0;
      cmd_z_q     <= '0;
      cmd_color_q <= '0;
      err_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      color_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_x0_q    <= cmd_x0_d;
      cmd_y0_q    <= cmd_y0_d;
      cmd_x1_q    <= cmd_x1_d;
      cmd_y1_q    <= cmd_y1_d;
      cmd_z_q     <= cmd_z_d;
      cmd_color_q <= cmd_color_d;
      err_q       <= err_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pw_q        <= pw_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign x           = x_q;
  assign y           = y_q;
  assign z           = z_q;
  assign pixel_color = color_q;
  assign pixel_write = pw_q;
  assign dbg_state   = state_q;

endmodule
